fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch unit with a DEPTH-entry instruction queue that decouples the instruction cache from the decoder. It issues one PC-ordered fetch request at a time, buffers returned instructions, and can optionally stall after control-flow instructions. It handles ROB and decoder redirects, discarding stale in-flight responses. It sits between the instruction cache and the decoder and replaces the single-register fetch stage.

## Interface
- XLEN, 32, address and instruction width.
- DEPTH, 4, queue entries; power of 2, at least 2.
- RESET_PC, 0, PC loaded at reset.
- STALL_ON_CTRL, 1, when 1, stop fetching after JAL, JALR or BRANCH until a redirect arrives.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; 0 freezes all state except response capture.
- clear  in  1  ROB redirect; highest priority.
- new_pc  in  XLEN  ROB redirect target.
- clear_decoder  in  1  decoder redirect.
- new_pc_decoder  in  XLEN  decoder redirect target.
- icache_req_valid  out  1  fetch request.
- icache_req_addr  out  XLEN  fetch address, equal to pc.
- icache_req_ready  in  1  cache accepts the request.
- icache_resp_valid  in  1  instruction returned.
- icache_resp_inst  in  XLEN  returned instruction.
- inst_valid  out  1  queue head valid.
- inst_addr  out  XLEN  PC of the head entry.
- inst  out  XLEN  head instruction.
- inst_ready  in  1  decoder consumes the head.
- queue_count  out  clog2(DEPTH+1)  occupied entries.

## Operation
- **State:** pc, circular queue of {addr, inst} with head/tail pointers and count, outstanding (1 bit), drop (1 bit), stalled (1 bit).
- **Reset values:** pc=RESET_PC; queue empty with pointers at 0; storage 0; outstanding, drop and stalled all 0. Consequently inst_valid=0, inst=0, inst_addr=0, queue_count=0, and icache_req_addr=RESET_PC.
- **Request eligibility:** icache_req_valid = rdy & !stalled & !drop & !clear & !clear_decoder & (count + outstanding < DEPTH) & (!outstanding | bypass).
  - bypass = icache_resp_valid & outstanding & !drop & !(STALL_ON_CTRL & the response is a control-flow instruction).
  - In the bypass case the space check uses count+1 in place of count+outstanding.
- **Request handshake:** icache_req_valid & icache_req_ready sets outstanding=1 and updates pc <= pc+4, wrapping modulo 2^XLEN.
- **Response handling:**
  - icache_resp_valid with outstanding & !drop pushes {pc of the request, inst} at the tail and clears outstanding.
  - With drop=1, the response is discarded and drop and outstanding are cleared.
  - A response with outstanding=0 is ignored.
  - Responses are captured even when rdy=0.
- **Control-flow stall:** when STALL_ON_CTRL=1 and a pushed instruction has opcode 1101111, 1100111 or 1100011, set stalled=1.
- **Pop:** inst_valid = rdy & count != 0. A pop occurs on inst_valid & inst_ready. Push and pop may occur in the same cycle; count is unchanged in that case.
- **Redirect (clear or clear_decoder):**
  - pc <= new_pc when clear=1, otherwise new_pc_decoder.
  - Queue is emptied and stalled is cleared.
  - If a request is outstanding or is accepted in the same cycle, drop is set to 1.
  - Any push or pop in the redirect cycle is cancelled.
  - Redirects are ignored while rdy=0.
- The queue never overflows because space is reserved at request time. Pushing into a full queue is therefore unreachable; assert on it in simulation.

## Timing
- Request accepted in cycle t, earliest response in t+1, entry visible at inst_valid in t+2.
- With a 1-cycle cache and a ready decoder, steady-state throughput is 1 instruction per cycle through the bypass.
- Redirect in cycle t: no request in cycle t; the first request to the new target is in t+1 when drop=0.
  - Otherwise it follows in the cycle after the stale response is discarded.
- Reset is asynchronous on assertion; mid-operation reset discards the queue and any in-flight request immediately.
- rdy=0 gates icache_req_valid and inst_valid to 0; state holds apart from response capture.

## Test plan
- **Reset:** hold rst low, then release → icache_req_valid=1, icache_req_addr=0x0, inst_valid=0, queue_count=0.
- **Streaming:** 1-cycle cache returning 0x00000013 (addi), inst_ready=1 → inst_addr sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles starting 2 cycles after the first handshake.
- **Back-pressure:** DEPTH=4, inst_ready=0 → exactly 4 requests issued, queue_count=4, icache_req_valid=0. One pop → exactly one new request at 0x10.
- **Control-flow stall:** 0x0080006F (JAL) at 0x8 → no request to 0xC. clear_decoder with 0x100 → queue_count=0, next icache_req_addr=0x100.
- **Stale response:** request at 0x10 accepted, clear with new_pc=0x200 next cycle, response 3 cycles later → response dropped, queue_count=0, the 0x200 request issued the cycle after the drop.
- **Priority and wrap:** clear=0x300 and clear_decoder=0x400 in the same cycle → pc=0x300. Redirect to 0xFFFFFFFC → requests 0xFFFFFFFC then 0x0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a DEPTH-entry instruction queue
// between the instruction cache and the decoder.
//
// Issues one PC-ordered request at a time. A slot in the queue is reserved
// when a request is issued, so a returning response always has room.
// While a response is arriving, the next request may be issued in the same
// cycle (bypass), which gives one instruction per cycle with a 1-cycle cache.
// Redirects from the ROB (clear) or the decoder (clear_decoder) flush the
// queue. A request still in flight at redirect time is marked to be dropped.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   rdy                   global enable; 0 freezes everything except response capture
//   clear, new_pc         ROB redirect (highest priority) and its target
//   clear_decoder,
//   new_pc_decoder        decoder redirect and its target
//   icache_req_*          fetch request to the cache (addr == pc)
//   icache_resp_*         instruction returned by the cache
//   inst_valid/addr/inst  queue head presented to the decoder
//   inst_ready            decoder consumes the head
//   queue_count           number of occupied entries
module fetch_queue #(
   parameter int               XLEN          = 32,
   parameter int               DEPTH         = 4,
   parameter logic [XLEN-1:0]  RESET_PC      = '0,
   parameter bit               STALL_ON_CTRL = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rdy,
   input  logic                         clear,
   input  logic [XLEN-1:0]              new_pc,
   input  logic                         clear_decoder,
   input  logic [XLEN-1:0]              new_pc_decoder,
   output logic                         icache_req_valid,
   output logic [XLEN-1:0]              icache_req_addr,
   input  logic                         icache_req_ready,
   input  logic                         icache_resp_valid,
   input  logic [XLEN-1:0]              icache_resp_inst,
   output logic                         inst_valid,
   output logic [XLEN-1:0]              inst_addr,
   output logic [XLEN-1:0]              inst,
   input  logic                         inst_ready,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] inst;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] pc;
   logic            outstanding, drop, stalled;

   logic            redirect, resp_hit, resp_ctrl, bypass, space_ok;
   logic            handshake, push, pop;
   logic [6:0]      opcode;

   assign opcode    = icache_resp_inst[6:0];
   assign resp_ctrl = STALL_ON_CTRL &&
                      (opcode == 7'b1101111 || opcode == 7'b1100111 || opcode == 7'b1100011);

   assign redirect  = rdy & (clear | clear_decoder);
   assign resp_hit  = icache_resp_valid & outstanding;
   assign bypass    = resp_hit & ~drop & ~resp_ctrl;

   // The in-flight request already holds a reserved slot, so the space check
   // is count + outstanding. In the bypass case outstanding is 1 and this is
   // exactly count + 1: the arriving response takes its slot and the new
   // request reserves the next one.
   assign space_ok  = ({1'b0, count} + {{CW{1'b0}}, outstanding}) < (CW+1)'(DEPTH);

   assign icache_req_valid = rdy & ~stalled & ~drop & ~clear & ~clear_decoder &
                             space_ok & (~outstanding | bypass);
   assign icache_req_addr  = pc;
   assign handshake        = icache_req_valid & icache_req_ready;

   // Responses are captured regardless of rdy; a redirect cancels the push.
   assign push        = resp_hit & ~drop & ~redirect;
   assign inst_valid  = rdy & (count != '0);
   assign pop         = inst_valid & inst_ready & ~redirect;

   assign inst_addr   = mem[head].addr;
   assign inst        = mem[head].inst;
   assign queue_count = count;

   // pc, in-flight tracking and control-flow stall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         stalled     <= 1'b0;
      end else if (redirect) begin
         pc      <= clear ? new_pc : new_pc_decoder;
         stalled <= 1'b0;
         if (resp_hit) begin
            // The in-flight request completes in this very cycle and its
            // data is discarded, so nothing is left to drop later.
            outstanding <= 1'b0;
            drop        <= 1'b0;
         end else begin
            outstanding <= outstanding | handshake;
            drop        <= outstanding | handshake;
         end
      end else begin
         if (handshake)
            pc <= pc + XLEN'(4);
         if (push && resp_ctrl)
            stalled <= 1'b1;
         if (resp_hit) begin
            drop        <= 1'b0;
            outstanding <= handshake;
         end else if (handshake) begin
            outstanding <= 1'b1;
         end
      end
   end

   // Circular instruction queue. The request address is pc - 4 at push time:
   // pc advanced on the handshake and cannot move again until the response
   // arrives (a redirect in between sets drop, so no push happens).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= '{addr: pc - XLEN'(4), inst: icache_resp_inst};
            tail      <= tail + PW'(1);
         end
         if (pop)
            head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Space is reserved at request time, so a push can never find the queue full.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
                                    push |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam bit STALL = 1'b1;

   logic              clk = 1'b0;
   logic              rst;
   logic              rdy, clear, clear_decoder;
   logic [XLEN-1:0]   new_pc, new_pc_decoder;
   logic              icache_req_valid, icache_req_ready;
   logic [XLEN-1:0]   icache_req_addr;
   logic              icache_resp_valid;
   logic [XLEN-1:0]   icache_resp_inst;
   logic              inst_valid, inst_ready;
   logic [XLEN-1:0]   inst_addr, inst;
   logic [2:0]        queue_count;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .STALL_ON_CTRL(STALL)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .new_pc(new_pc),
      .clear_decoder(clear_decoder), .new_pc_decoder(new_pc_decoder),
      .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
      .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
      .icache_resp_inst(icache_resp_inst), .inst_valid(inst_valid),
      .inst_addr(inst_addr), .inst(inst), .inst_ready(inst_ready),
      .queue_count(queue_count)
   );

   int errors = 0;
   int checks = 0;

   // reference model: a plain queue of fetched entries plus a few flags
   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc, m_req_addr;
   bit          m_out, m_drop, m_stall;
   bit          e_req_valid, e_inst_valid;
   int          e_count;
   logic [31:0] e_req_addr, e_inst_addr, e_inst;

   // output snapshot taken each cycle
   logic        a_req_valid, a_inst_valid;
   logic [31:0] a_req_addr, a_inst_addr, a_inst;
   logic [2:0]  a_count;

   // cache environment: at most one pending response
   bit          p_valid;
   logic [31:0] p_addr;
   int          p_due, lat, cycnum;
   bit          rnd_mode, spur;
   logic [31:0] imem [logic [31:0]];

   function automatic bit is_ctrl(logic [31:0] i);
      return i[6:0] == 7'h6F || i[6:0] == 7'h67 || i[6:0] == 7'h63;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      logic [6:0]  opc;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: opc = 7'h6F;
         1: opc = 7'h67;
         2: opc = 7'h63;
         default: opc = 7'h13;
      endcase
      return {r[31:7], opc};
   endfunction

   task automatic model_comb();
      bit bypass, space;
      bypass = icache_resp_valid && m_out && !m_drop && !(STALL && is_ctrl(icache_resp_inst));
      space  = bypass ? (mq.size() + 1 < DEPTH) : (mq.size() + int'(m_out) < DEPTH);
      e_req_valid  = rdy && !m_stall && !m_drop && !clear && !clear_decoder && space &&
                     (!m_out || bypass);
      e_req_addr   = m_pc;
      e_count      = mq.size();
      e_inst_valid = rdy && (mq.size() != 0);
      e_inst_addr  = (mq.size() != 0) ? mq[0].addr : 32'h0;
      e_inst       = (mq.size() != 0) ? mq[0].inst : 32'h0;
   endtask

   task automatic model_step();
      bit   redir, resp_hit, hs, do_pop;
      ent_t e;
      redir    = rdy && (clear || clear_decoder);
      resp_hit = icache_resp_valid && m_out;
      hs       = e_req_valid && icache_req_ready;
      do_pop   = e_inst_valid && inst_ready;
      if (redir) begin
         m_pc = clear ? new_pc : new_pc_decoder;
         mq.delete();
         m_stall = 0;
         if (resp_hit) begin
            m_out  = 0;
            m_drop = 0;
         end else begin
            m_drop = m_out;
         end
      end else begin
         if (do_pop) mq.delete(0);
         if (resp_hit) begin
            if (!m_drop) begin
               e.addr = m_req_addr;
               e.inst = icache_resp_inst;
               mq.push_back(e);
               if (STALL && is_ctrl(icache_resp_inst)) m_stall = 1;
            end
            m_out  = 0;
            m_drop = 0;
         end
         if (hs) begin
            m_req_addr = m_pc;
            m_pc       = m_pc + 32'd4;
            m_out      = 1;
         end
      end
   endtask

   // One clock cycle; entered and left just after a falling edge.
   task automatic cyc();
      bit resp_due;
      resp_due = p_valid && (cycnum >= p_due);
      if (resp_due) begin
         if (rnd_mode && !imem.exists(p_addr)) imem[p_addr] = rand_inst();
         icache_resp_valid = 1'b1;
         icache_resp_inst  = imem.exists(p_addr) ? imem[p_addr] : 32'h0000_0013;
      end else begin
         icache_resp_valid = spur;
         icache_resp_inst  = $urandom;
      end
      #1;
      model_comb();
      a_req_valid  = icache_req_valid;
      a_req_addr   = icache_req_addr;
      a_inst_valid = inst_valid;
      a_inst_addr  = inst_addr;
      a_inst       = inst;
      a_count      = queue_count;
      model_step();
      if (resp_due) p_valid = 0;
      if (a_req_valid === 1'b1 && icache_req_ready) begin
         p_valid = 1;
         p_addr  = a_req_addr;
         p_due   = cycnum + lat;
      end
      cycnum++;
      @(negedge clk);
   endtask

   task automatic set_idle();
      rdy = 1; clear = 0; clear_decoder = 0; new_pc = 0; new_pc_decoder = 0;
      icache_req_ready = 1; icache_resp_valid = 0; icache_resp_inst = 0;
      inst_ready = 0; spur = 0; lat = 1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 0;
      p_valid = 0; rnd_mode = 0; imem.delete();
      mq.delete(); m_pc = 0; m_req_addr = 0; m_out = 0; m_drop = 0; m_stall = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      cycnum = 0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 0;
      @(negedge clk);
      #1;
      checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst); end
      checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL reset_inst_addr: got %h expected 0", inst_addr); end
      do_reset();
      cyc();
      checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b expected 1", a_req_valid); end
      checks++; if (a_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", a_req_addr); end
      checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL reset_count_rel: got %0d expected 0", a_count); end
   endtask

   task automatic test_streaming();
      do_reset();
      inst_ready = 1;
      for (int c = 0; c < 8; c++) begin
         cyc();
         checks++;
         if (a_req_valid !== 1'b1 || a_req_addr !== 32'(4 * c)) begin
            errors++; $display("FAIL stream_req c=%0d: got v=%b a=%h expected v=1 a=%h", c, a_req_valid, a_req_addr, 4 * c);
         end
         if (c >= 2) begin
            checks++;
            if (a_inst_valid !== 1'b1 || a_inst_addr !== 32'(4 * (c - 2)) || a_inst !== 32'h13) begin
               errors++; $display("FAIL stream_head c=%0d: got v=%b a=%h i=%h expected v=1 a=%h i=00000013",
                                  c, a_inst_valid, a_inst_addr, a_inst, 4 * (c - 2));
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      int          n;
      logic [31:0] first;
      do_reset();
      n = 0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (a_req_valid === 1'b1) n++;
      end
      checks++; if (n != 4) begin errors++; $display("FAIL bp_requests: got %0d expected 4", n); end
      checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", a_count); end
      checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", a_req_valid); end
      inst_ready = 1;
      cyc();
      checks++; if (a_inst_valid !== 1'b1 || a_inst_addr !== 32'h0) begin
         errors++; $display("FAIL bp_pop: got v=%b a=%h expected v=1 a=00000000", a_inst_valid, a_inst_addr);
      end
      inst_ready = 0;
      n = 0; first = 32'hDEAD_BEEF;
      for (int c = 0; c < 6; c++) begin
         cyc();
         if (a_req_valid === 1'b1) begin
            if (n == 0) first = a_req_addr;
            n++;
         end
      end
      checks++; if (n != 1 || first !== 32'h10) begin
         errors++; $display("FAIL bp_refill: got n=%0d addr=%h expected n=1 addr=00000010", n, first);
      end
      checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL bp_count2: got %0d expected 4", a_count); end
      // asynchronous reset mid-operation, away from any clock edge
      #2 rst = 0;
      #1;
      checks++; if (queue_count !== 3'd0 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset: got count=%0d v=%b expected 0 0", queue_count, inst_valid);
      end
   endtask

   task automatic test_ctrl_stall();
      bit bad;
      do_reset();
      imem[32'h8] = 32'h0080_006F;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         cyc();
         if (c < 3) begin
            checks++;
            if (a_req_valid !== 1'b1 || a_req_addr !== 32'(4 * c)) begin
               errors++; $display("FAIL ctrl_req c=%0d: got v=%b a=%h expected v=1 a=%h", c, a_req_valid, a_req_addr, 4 * c);
            end
         end else if (a_req_valid !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL ctrl_stall: got a request after JAL expected none"); end
      checks++; if (a_count !== 3'd3 || a_req_addr !== 32'hC) begin
         errors++; $display("FAIL ctrl_state: got count=%0d pc=%h expected 3 0000000c", a_count, a_req_addr);
      end
      clear_decoder = 1; new_pc_decoder = 32'h100;
      cyc();
      checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL ctrl_redir_cycle: got v=%b expected 0", a_req_valid); end
      clear_decoder = 0;
      cyc();
      checks++; if (a_count !== 3'd0 || a_req_valid !== 1'b1 || a_req_addr !== 32'h100) begin
         errors++; $display("FAIL ctrl_redirect: got count=%0d v=%b a=%h expected 0 1 00000100", a_count, a_req_valid, a_req_addr);
      end
   endtask

   task automatic test_stale();
      bit bad;
      do_reset();
      lat = 4;
      clear_decoder = 1; new_pc_decoder = 32'h10;
      cyc();
      clear_decoder = 0;
      cyc();
      checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h10) begin
         errors++; $display("FAIL stale_req: got v=%b a=%h expected v=1 a=00000010", a_req_valid, a_req_addr);
      end
      clear = 1; new_pc = 32'h200;
      cyc();
      clear = 0;
      bad = (a_req_valid !== 1'b0);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         if (a_req_valid !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL stale_wait: got a request before drop expected none"); end
      cyc();
      checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h200 || a_count !== 3'd0) begin
         errors++; $display("FAIL stale_after: got v=%b a=%h count=%0d expected 1 00000200 0", a_req_valid, a_req_addr, a_count);
      end
   endtask

   task automatic test_priority_wrap();
      do_reset();
      inst_ready = 1;
      clear = 1; new_pc = 32'h300; clear_decoder = 1; new_pc_decoder = 32'h400;
      cyc();
      clear = 0; clear_decoder = 0; icache_req_ready = 0;
      cyc();
      checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h300) begin
         errors++; $display("FAIL priority: got v=%b a=%h expected v=1 a=00000300", a_req_valid, a_req_addr);
      end
      icache_req_ready = 1; clear_decoder = 1; new_pc_decoder = 32'hFFFF_FFFC;
      cyc();
      clear_decoder = 0;
      cyc();
      checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_req0: got v=%b a=%h expected v=1 a=fffffffc", a_req_valid, a_req_addr);
      end
      cyc();
      checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_req1: got v=%b a=%h expected v=1 a=00000000", a_req_valid, a_req_addr);
      end
      cyc();
      checks++; if (a_inst_valid !== 1'b1 || a_inst_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_head0: got v=%b a=%h expected v=1 a=fffffffc", a_inst_valid, a_inst_addr);
      end
      cyc();
      checks++; if (a_inst_valid !== 1'b1 || a_inst_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_head1: got v=%b a=%h expected v=1 a=00000000", a_inst_valid, a_inst_addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      do_reset();
      rnd_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         rdy              = ($urandom_range(0, 9) != 0);
         inst_ready       = ($urandom_range(0, 9) < 7);
         icache_req_ready = ($urandom_range(0, 9) < 8);
         lat              = $urandom_range(1, 3);
         clear            = ($urandom_range(0, 31) == 0) || (m_stall && $urandom_range(0, 7) == 0);
         clear_decoder    = ($urandom_range(0, 31) == 0) || (m_stall && $urandom_range(0, 7) == 0);
         r = $urandom; new_pc = {r[31:2], 2'b00};
         r = $urandom; new_pc_decoder = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
         spur = !p_valid && ($urandom_range(0, 15) == 0);
         cyc();
         checks++; if (a_req_valid !== e_req_valid) begin
            errors++; $display("FAIL rnd_req_valid c=%0d: got %b expected %b", c, a_req_valid, e_req_valid);
         end
         checks++; if (a_req_addr !== e_req_addr) begin
            errors++; $display("FAIL rnd_req_addr c=%0d: got %h expected %h", c, a_req_addr, e_req_addr);
         end
         checks++; if (a_inst_valid !== e_inst_valid) begin
            errors++; $display("FAIL rnd_inst_valid c=%0d: got %b expected %b", c, a_inst_valid, e_inst_valid);
         end
         checks++; if (a_count !== 3'(e_count)) begin
            errors++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, a_count, e_count);
         end
         if (e_count != 0) begin
            checks++; if (a_inst_addr !== e_inst_addr || a_inst !== e_inst) begin
               errors++; $display("FAIL rnd_head c=%0d: got a=%h i=%h expected a=%h i=%h",
                                  c, a_inst_addr, a_inst, e_inst_addr, e_inst);
            end
         end
      end
      spur = 0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_ctrl_stall();
      test_stale();
      test_priority_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
